// File: rtl/lcd_dual_view_pkg.sv
// Shared definitions for the dual-view LCD stage: window-B modes, region tags
// and the fixed-point luma coefficients used by the gray pipeline.
package lcd_dual_view_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_BIN  = 2'd2,
        MODE_INV  = 2'd3
    } view_mode_t;

    typedef enum logic [1:0] {
        TAG_BG = 2'd0,
        TAG_A  = 2'd1,
        TAG_B  = 2'd2
    } region_tag_t;

    // Coefficients sum to 255, so the shifted result never exceeds 254.
    localparam logic [7:0] GRAY_COEF_R = 8'd76;
    localparam logic [7:0] GRAY_COEF_G = 8'd150;
    localparam logic [7:0] GRAY_COEF_B = 8'd29;
    localparam int         GRAY_SHIFT  = 8;

endpackage

// File: rtl/lcd_dual_view_rgb2gray_pipe.sv
// Two-stage RGB888 to 8-bit gray calculator that carries the raw pixel
// alongside, so later filters can choose between colour and luma.
module rgb2gray_pipe
    import lcd_dual_view_pkg::*;
(
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb_out,
    output logic [7:0]  gray_out
);

    logic [15:0] prod_r;
    logic [15:0] prod_g;
    logic [15:0] prod_b;
    logic [23:0] rgb_p1;
    logic [17:0] gray_sum;

    assign gray_sum = {2'b00, prod_r} + {2'b00, prod_g} + {2'b00, prod_b};

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= '0;
            prod_g   <= '0;
            prod_b   <= '0;
            rgb_p1   <= '0;
            rgb_out  <= '0;
            gray_out <= '0;
        end else begin
            prod_r   <= {8'd0, rgb_in[23:16]} * {8'd0, GRAY_COEF_R};
            prod_g   <= {8'd0, rgb_in[15:8]}  * {8'd0, GRAY_COEF_G};
            prod_b   <= {8'd0, rgb_in[7:0]}   * {8'd0, GRAY_COEF_B};
            rgb_p1   <= rgb_in;
            rgb_out  <= rgb_p1;
            gray_out <= 8'(gray_sum >> GRAY_SHIFT);
        end
    end

endmodule

// File: rtl/lcd_dual_view.sv
// Shows one ROM image twice per frame: original in window A, a per-frame
// selectable processed copy in window B. Latency is ROM_LAT+4 pixel clocks.
module lcd_dual_view
    import lcd_dual_view_pkg::*;
#(
    parameter int          PIC_XA   = 2,
    parameter int          PIC_XB   = 302,
    parameter int          PIC_Y0   = 0,
    parameter int          PIC_W    = 250,
    parameter int          PIC_H    = 250,
    parameter int          ADDR_W   = 16,
    parameter int          ROM_LAT  = 1,
    parameter logic [23:0] BG_COLOR = 24'hFFFFFF
) (
    input  logic              lcd_pclk,
    input  logic              rst_n,
    input  logic [10:0]       pixel_xpos,
    input  logic [10:0]       pixel_ypos,
    input  logic [1:0]        mode,
    input  logic [7:0]        thresh,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_rd_data,
    output logic [1:0]        frame_mode,
    output logic [23:0]       pixel_data
);

    // Tag must line up with the gray pipe output: 1 address + ROM_LAT + 2 stages.
    localparam int TAG_DEPTH = ROM_LAT + 3;

    int                xi;
    int                yi;
    int                col_i;
    logic              in_y;
    logic              in_a;
    logic              in_b;
    logic              frame_start;
    logic              row_end;
    region_tag_t       region;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_eff;
    logic [7:0]        thresh_lat;
    region_tag_t       tag_pipe [TAG_DEPTH];
    region_tag_t       tag_out;
    logic [23:0]       rgb_p2;
    logic [7:0]        gray_p2;

    assign xi          = {21'd0, pixel_xpos};
    assign yi          = {21'd0, pixel_ypos};
    assign in_y        = (yi >= PIC_Y0) && (yi < PIC_Y0 + PIC_H);
    assign in_a        = in_y && (xi >= PIC_XA) && (xi < PIC_XA + PIC_W);
    assign in_b        = in_y && (xi >= PIC_XB) && (xi < PIC_XB + PIC_W);
    assign frame_start = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    assign row_end     = in_y && (xi == PIC_XB + PIC_W - 1);
    assign region      = in_a ? TAG_A : (in_b ? TAG_B : TAG_BG);
    assign col_i       = in_a ? (xi - PIC_XA) : (xi - PIC_XB);
    assign row_base_eff = frame_start ? '0 : row_base;
    assign tag_out     = tag_pipe[TAG_DEPTH-1];

    // Addressing and the per-frame latch; row_base restarts every frame so a
    // partial frame (e.g. after reset) cannot leave an offset behind.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            row_base   <= '0;
            frame_mode <= MODE_PASS;
            thresh_lat <= '0;
        end else begin
            if (region != TAG_BG) begin
                rom_addr <= row_base_eff + ADDR_W'(col_i);
            end
            if (frame_start) begin
                row_base   <= '0;
                frame_mode <= mode;
                thresh_lat <= thresh;
            end else if (row_end) begin
                row_base <= row_base + ADDR_W'(PIC_W);
            end
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= TAG_BG;
            end
        end else begin
            tag_pipe[0] <= region;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    rgb2gray_pipe u_gray (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .rgb_in   (rom_rd_data),
        .rgb_out  (rgb_p2),
        .gray_out (gray_p2)
    );

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data <= BG_COLOR;
        end else begin
            case (tag_out)
                TAG_A: pixel_data <= rgb_p2;
                TAG_B: begin
                    case (view_mode_t'(frame_mode))
                        MODE_PASS: pixel_data <= rgb_p2;
                        MODE_GRAY: pixel_data <= {3{gray_p2}};
                        MODE_BIN:  pixel_data <= (gray_p2 >= thresh_lat) ? 24'hFFFFFF : 24'h000000;
                        default:   pixel_data <= {3{~gray_p2}};
                    endcase
                end
                default: pixel_data <= BG_COLOR;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_dual_view.sv
// Scoreboard bench for lcd_dual_view: scans small frames, queues hand-derived
// expectations per coordinate and checks them when they emerge from the pipe.
module tb_lcd_dual_view;

    localparam int PIC_XA  = 2;
    localparam int PIC_XB  = 22;
    localparam int PIC_Y0  = 0;
    localparam int PIC_W   = 16;
    localparam int PIC_H   = 8;
    localparam int ADDR_W  = 8;
    localparam int ROM_LAT = 1;
    localparam int OUT_LAT = ROM_LAT + 4;
    localparam int H_TOTAL = 40;
    localparam int V_TOTAL = 10;
    localparam logic [23:0] BG = 24'hFFFFFF;

    logic              lcd_pclk = 1'b0;
    logic              rst_n;
    logic [10:0]       pixel_xpos;
    logic [10:0]       pixel_ypos;
    logic [1:0]        mode;
    logic [7:0]        thresh;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_rd_data;
    logic [1:0]        frame_mode;
    logic [23:0]       pixel_data;

    lcd_dual_view #(
        .PIC_XA   (PIC_XA),
        .PIC_XB   (PIC_XB),
        .PIC_Y0   (PIC_Y0),
        .PIC_W    (PIC_W),
        .PIC_H    (PIC_H),
        .ADDR_W   (ADDR_W),
        .ROM_LAT  (ROM_LAT),
        .BG_COLOR (BG)
    ) dut (
        .lcd_pclk    (lcd_pclk),
        .rst_n       (rst_n),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .mode        (mode),
        .thresh      (thresh),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .frame_mode  (frame_mode),
        .pixel_data  (pixel_data)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    // One-cycle ROM: either a constant colour or its own address as data.
    logic        rom_index;
    logic [23:0] rom_color;
    always @(posedge lcd_pclk) begin
        rom_rd_data <= rom_index ? {{(24-ADDR_W){1'b0}}, rom_addr} : rom_color;
    end

    typedef struct packed {
        logic [23:0] pix;
        logic        chk_fm;
        logic [1:0]  fm;
        logic [10:0] x;
        logic [10:0] y;
    } pix_item_t;

    typedef struct packed {
        logic              chk;
        logic [ADDR_W-1:0] addr;
        logic [10:0]       x;
        logic [10:0]       y;
    } addr_item_t;

    typedef struct packed {
        logic        idx;
        logic [23:0] color;
        logic [1:0]  mode;
        logic [7:0]  thr;
        logic        mid_en;
        logic [1:0]  mode_mid;
        logic [7:0]  thr_mid;
        logic        do_reset;
        logic [23:0] exp_b;
    } frame_vec_t;

    pix_item_t         pix_q[$];
    addr_item_t        addr_q[$];
    frame_vec_t        vec_q[$];
    logic              issue;
    logic [OUT_LAT-1:0] vld_sr;
    int                n_checks = 0;
    int                n_fail = 0;
    logic [1:0]        exp_fm;
    logic [ADDR_W-1:0] last_addr;
    logic              addr_known;

    task automatic checkOutput(input string name, input logic [23:0] act,
                               input logic [23:0] exp, input int x, input int y);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("[TB] FAIL %s at x=%0d y=%0d: got %h, expected %h", name, x, y, act, exp);
        end
    endtask

    // Issue flags ride alongside the DUT pipeline; a reset drops them all.
    always @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) vld_sr <= '0;
        else        vld_sr <= {vld_sr[OUT_LAT-2:0], issue};
    end

    always @(negedge lcd_pclk) begin
        if (vld_sr[0]) begin
            if (addr_q.size() == 0) begin
                checkOutput("addr_queue_empty", 24'd1, 24'd0, 0, 0);
            end else begin
                addr_item_t a;
                a = addr_q.pop_front();
                if (a.chk)
                    checkOutput("rom_addr", {{(24-ADDR_W){1'b0}}, rom_addr},
                                {{(24-ADDR_W){1'b0}}, a.addr}, a.x, a.y);
            end
        end
        if (vld_sr[OUT_LAT-1]) begin
            if (pix_q.size() == 0) begin
                checkOutput("pix_queue_empty", 24'd1, 24'd0, 0, 0);
            end else begin
                pix_item_t p;
                p = pix_q.pop_front();
                checkOutput("pixel_data", pixel_data, p.pix, p.x, p.y);
                if (p.chk_fm)
                    checkOutput("frame_mode", {22'd0, frame_mode}, {22'd0, p.fm}, p.x, p.y);
            end
        end
    end

    task automatic applyStimulus(input int x, input int y, input logic track, input frame_vec_t v);
        logic in_y, in_a, in_b;
        logic [ADDR_W-1:0] addr;
        logic [23:0] pix;
        @(posedge lcd_pclk);
        #1;
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        issue      = track;
        if (track) begin
            in_y = (y >= PIC_Y0) && (y < PIC_Y0 + PIC_H);
            in_a = in_y && (x >= PIC_XA) && (x < PIC_XA + PIC_W);
            in_b = in_y && (x >= PIC_XB) && (x < PIC_XB + PIC_W);
            if (x == 0 && y == 0) exp_fm = mode;
            addr = '0;
            pix  = BG;
            if (in_a || in_b) begin
                addr = ADDR_W'((y - PIC_Y0) * PIC_W + (x - (in_a ? PIC_XA : PIC_XB)));
                last_addr  = addr;
                addr_known = 1'b1;
            end
            if (in_a) pix = v.idx ? {{(24-ADDR_W){1'b0}}, addr} : v.color;
            if (in_b) pix = v.idx ? {{(24-ADDR_W){1'b0}}, addr} : v.exp_b;
            addr_q.push_back('{chk: addr_known, addr: last_addr, x: 11'(x), y: 11'(y)});
            pix_q.push_back('{pix: pix, chk_fm: (y < V_TOTAL - 1), fm: exp_fm,
                              x: 11'(x), y: 11'(y)});
        end
    endtask

    task automatic doReset();
        issue      = 1'b0;
        rst_n      = 1'b0;
        addr_known = 1'b0;
        pix_q.delete();
        addr_q.delete();
        repeat (3) begin
            @(negedge lcd_pclk);
            checkOutput("reset_pixel", pixel_data, BG, 0, 0);
            checkOutput("reset_addr", {{(24-ADDR_W){1'b0}}, rom_addr}, 24'd0, 0, 0);
        end
        @(posedge lcd_pclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic runFrame(input frame_vec_t v);
        logic track;
        track     = 1'b1;
        rom_index = v.idx;
        rom_color = v.color;
        mode      = v.mode;
        thresh    = v.thr;
        for (int y = 0; y < V_TOTAL; y++) begin
            for (int x = 0; x < H_TOTAL; x++) begin
                if (v.mid_en && y == 4 && x == 0) begin
                    mode   = v.mode_mid;
                    thresh = v.thr_mid;
                end
                if (v.do_reset && y == 5 && x == 10) begin
                    doReset();
                    track = 1'b0;
                end
                applyStimulus(x, y, track, v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        pixel_xpos = '0;
        pixel_ypos = '0;
        mode       = '0;
        thresh     = '0;
        issue      = 1'b0;
        rom_index  = 1'b0;
        rom_color  = '0;
        exp_fm     = '0;
        last_addr  = '0;
        addr_known = 1'b0;

        //            idx   color         md    thr    mid   mmid  tmid   rst   exp_b
        vec_q.push_back({1'b0, 24'hFF0000, 2'd1, 8'd0,   1'b0, 2'd0, 8'd0, 1'b0, 24'h4B4B4B});
        vec_q.push_back({1'b0, 24'h00FF00, 2'd2, 8'd150, 1'b1, 2'd2, 8'd0, 1'b0, 24'h000000});
        vec_q.push_back({1'b0, 24'h00FF00, 2'd2, 8'd149, 1'b0, 2'd0, 8'd0, 1'b0, 24'hFFFFFF});
        vec_q.push_back({1'b0, 24'h0000FF, 2'd3, 8'd0,   1'b0, 2'd0, 8'd0, 1'b0, 24'hE3E3E3});
        vec_q.push_back({1'b0, 24'hFFFFFF, 2'd1, 8'd0,   1'b0, 2'd0, 8'd0, 1'b0, 24'hFEFEFE});
        vec_q.push_back({1'b1, 24'h000000, 2'd0, 8'd0,   1'b0, 2'd0, 8'd0, 1'b0, 24'h000000});
        vec_q.push_back({1'b1, 24'h000000, 2'd0, 8'd0,   1'b0, 2'd0, 8'd0, 1'b0, 24'h000000});
        vec_q.push_back({1'b0, 24'hFF0000, 2'd1, 8'd0,   1'b1, 2'd3, 8'd0, 1'b0, 24'h4B4B4B});
        vec_q.push_back({1'b0, 24'hFF0000, 2'd3, 8'd0,   1'b0, 2'd0, 8'd0, 1'b0, 24'hB4B4B4});
        vec_q.push_back({1'b1, 24'h000000, 2'd0, 8'd0,   1'b0, 2'd0, 8'd0, 1'b1, 24'h000000});
        vec_q.push_back({1'b1, 24'h000000, 2'd0, 8'd0,   1'b0, 2'd0, 8'd0, 1'b0, 24'h000000});

        repeat (3) @(posedge lcd_pclk);
        @(negedge lcd_pclk);
        checkOutput("init_pixel", pixel_data, BG, 0, 0);
        checkOutput("init_addr", {{(24-ADDR_W){1'b0}}, rom_addr}, 24'd0, 0, 0);
        checkOutput("init_frame_mode", {22'd0, frame_mode}, 24'd0, 0, 0);
        rst_n = 1'b1;

        foreach (vec_q[i]) runFrame(vec_q[i]);

        @(posedge lcd_pclk);
        #1;
        issue = 1'b0;
        repeat (OUT_LAT + 2) @(posedge lcd_pclk);
        @(negedge lcd_pclk);
        checkOutput("pix_queue_drained", 24'(pix_q.size()), 24'd0, 0, 0);
        checkOutput("addr_queue_drained", 24'(addr_q.size()), 24'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_dual_view.md
Name: lcd_dual_view

Overview:
- Parametrised successor of the single-image gray display stage.
- Reads one RGB888 image from an external ROM and shows it twice per frame, side by side: the original in window A and a processed copy in window B.
- Window B mode is selectable per frame: pass, gray, binary threshold or inverted gray.
- Sits between the LCD timing driver (supplies pixel coordinates) and the LCD pixel bus. Fixed latency, fully pipelined, one pixel per clock.

Parameters:
- PIC_XA, 2, window A left x
- PIC_XB, 302, window B left x; must be >= PIC_XA+PIC_W
- PIC_Y0, 0, top y of both windows
- PIC_W, 250, image width in pixels
- PIC_H, 250, image height in pixels
- ADDR_W, 16, ROM address width; PIC_W*PIC_H <= 2^ADDR_W
- ROM_LAT, 1, ROM read latency in clocks (>=1)
- BG_COLOR, 24'hFFFFFF, colour outside both windows

Ports:
- lcd_pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pixel_xpos  in  11  current x coordinate
- pixel_ypos  in  11  current y coordinate
- mode  in  2  requested window-B mode: 0 pass, 1 gray, 2 binary, 3 inverted gray
- thresh  in  8  binary threshold
- rom_addr  out  ADDR_W  registered ROM address
- rom_rd_data  in  24  ROM data, {R,G,B}, valid ROM_LAT clocks after rom_addr
- frame_mode  out  2  mode latched for the current frame
- pixel_data  out  24  output pixel {R,G,B}

Behaviour:
- Clock and reset: one clock, lcd_pclk. rst_n is asynchronous, active-low.
- Reset values:
  - pixel_data = BG_COLOR
  - rom_addr = 0
  - frame_mode = 0; thresh latch = 0
  - all pipeline tags = BG; row_base = 0
- Latency: OUT_LAT = ROM_LAT+4. The coordinate presented at cycle t produces pixel_data at cycle t+OUT_LAT. The LCD driver advances coordinates by OUT_LAT.
- Region decode (stage 0, combinational on inputs):
  - inY = pixel_ypos in [PIC_Y0, PIC_Y0+PIC_H)
  - A = inY and pixel_xpos in [PIC_XA, PIC_XA+PIC_W)
  - B = inY and pixel_xpos in [PIC_XB, PIC_XB+PIC_W)
  - else BG. A and B are mutually exclusive by parameter rule.
- Addressing, registered at t+1:
  - col = x-PIC_XA in A, x-PIC_XB in B.
  - rom_addr = row_base+col; rom_addr holds its value in BG.
  - row_base is cleared at frame start (pixel_xpos==0 and pixel_ypos==0).
  - row_base += PIC_W on the cycle x==PIC_XB+PIC_W-1 while inY.
  - Result: address wraps to 0 every frame. No carry from a partial frame survives a frame start.
- Frame latch: at frame start, frame_mode<=mode and thresh latch<=thresh. Changes to mode or thresh mid-frame have no effect until the next frame start.
- Pipeline:
  - Region tag {BG,A,B} is delayed by a shift register aligned with the data path.
  - P1 (ROM data cycle+1): registers products 76*R, 150*G, 29*B (16 bit each) and the raw RGB.
  - P2: registers gray = (sum, 18 bit) >> 8 (8 bit, max 254) and the raw RGB.
  - P3 output mux, by tag:
    - A: pixel_data = raw RGB.
    - B, mode 0: raw RGB.
    - B, mode 1: {3{gray}}.
    - B, mode 2: gray>=thresh ? FFFFFF : 000000.
    - B, mode 3: {3{~gray}}.
    - BG: BG_COLOR.
  - Mode and thresh are sampled by P3 from the frame latch. A frame-start latch takes effect for the first pixel of that frame, because the latch leads the pipeline by OUT_LAT.
- Boundary conditions:
  - Last pixel of a window row increments correctly.
  - y >= PIC_Y0+PIC_H is all BG.
  - Coordinates above 2047 are not possible (11 bit).
  - Reset mid-frame: outputs return to BG immediately. The first full image follows the next frame start.

Decomposition:
- Package lcd_dual_view_pkg:
  - mode encodings MODE_PASS/GRAY/BIN/INV
  - gray coefficients 76/150/29 and shift 8
  - tag encoding
- One sub-module: rgb2gray_pipe, a 2-stage P1/P2 gray calculator with a raw-RGB passthrough. It is reusable by later filter blocks.

Test Plan:
- ROM all FF0000, mode 1, scan frame → window A pixels FF0000, window B 4B4B4B, BG elsewhere FFFFFF. Check that the first A pixel appears exactly OUT_LAT=5 clocks after x=2,y=0.
- ROM pixel 00FF00, mode 2, thresh 150 → B 000000; thresh 149 → B FFFFFF (gray 0x95).
- ROM 0000FF, mode 3 → B E3E3E3 (~0x1C). ROM FFFFFF, mode 1 → FEFEFE.
- ROM content = address index → rom_addr sequence per row:
  - row 0: 0..249 in A, then 0..249 in B
  - row 1: 250..499 in both windows
  - rom_addr returns to 0 after the next frame start.
- Change mode 1→3 at y=100 mid-frame → whole frame stays gray; the next frame is inverted from its first B pixel; frame_mode updates at frame start.
- Assert rst_n low at y=120 for 3 clocks → pixel_data FFFFFF and rom_addr 0 during reset. After the next frame start the image is intact, with no address offset.
